imem_arbiter: RTL
=================

# imem_arbiter

Shares the single-port synchronous instruction memory between two requesters. The core fetch stage uses it for reads. The program loader/debug port uses it for reads and writes, and can lock the memory for the length of a program-load burst. The block sits between the fetch stage, the loader and the memory macro. It handles arbitration, address range checks, response routing and the lock state machine.

## Interface
- `MEM_BYTES`, default 4096: addressable bytes. Byte addresses at or above this value are out of range.
- `DEPTH_WORDS`, default 1024: memory depth in 32-bit words. Equals `MEM_BYTES/4`.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, synchronous, active-low.
- `f_req_i`  in  1  fetch read request.
- `f_addr_i`  in  32  fetch byte address.
- `f_gnt_o`  out  1  fetch request accepted this cycle.
- `f_rvalid_o`  out  1  fetch response valid.
- `f_rdata_o`  out  32  fetch read data.
- `f_err_o`  out  1  fetch access error, qualified by `f_rvalid_o`.
- `l_req_i`  in  1  loader request.
- `l_we_i`  in  1  loader write enable.
- `l_addr_i`  in  32  loader byte address.
- `l_wdata_i`  in  32  loader write data.
- `l_lock_i`  in  1  loader requests exclusive ownership.
- `l_gnt_o`  out  1  loader request accepted.
- `l_rvalid_o`  out  1  loader response valid; also acknowledges writes.
- `l_rdata_o`  out  32  loader read data.
- `l_err_o`  out  1  loader access error.
- `l_locked_o`  out  1  lock is held.
- `mem_en_o`  out  1  memory access strobe.
- `mem_we_o`  out  1  memory write.
- `mem_addr_o`  out  $clog2(DEPTH_WORDS)  word index.
- `mem_wdata_o`  out  32  memory write data.
- `mem_rdata_i`  in  32  memory read data. It is valid in the cycle after `mem_en_o`.

## Operation
- FSM states:
  - ARB: normal arbitration.
  - LOCK_DRAIN: fetch is blocked and the outstanding response retires.
  - LOCKED: only the loader is served.
- ARB → LOCK_DRAIN when `l_lock_i`=1.
- LOCK_DRAIN → LOCKED once no response is outstanding.
- LOCKED → ARB when `l_lock_i`=0.
- LOCK_DRAIN → ARB if `l_lock_i` drops before LOCKED is reached.
- `l_locked_o` is 1 only in LOCKED.
- Arbitration in ARB:
  - With one request pending, that request is granted.
  - With both pending, the port not granted most recently wins (round-robin).
  - The last-grant pointer updates on every grant.
- In LOCK_DRAIN and LOCKED, `f_gnt_o`=0. The loader may be granted in either state.
- Grant is combinational from req in the same cycle. At most one grant per cycle.
- A granted access is valid when the address is below `MEM_BYTES` and `addr[1:0]`=0. A valid access drives `mem_en_o`=1, `mem_addr_o`=`addr[11:2]`, and `mem_we_o`=`l_we_i` for loader grants only.
- A granted access that is out of range or misaligned issues no memory access. Its response returns rdata=0 with err=1.
- Response owner and error flag are registered at grant. The response is routed to the owner's rvalid/rdata/err next cycle.
- The non-owner's rdata is held at 0.
- Write responses return rdata=0.

## Timing
- Reset values: all `*_gnt_o`, `*_rvalid_o`, `*_err_o`, `*_rdata_o`, `mem_*_o` and `l_locked_o` are 0. State is ARB. Last-grant pointer is loader, so fetch wins the first contention.
- Read latency: rvalid is exactly 1 cycle after gnt. Throughput is 1 access per cycle, back-to-back.
- Requesters hold addr/wdata/we stable while req=1 and gnt=0. Req may drop after gnt.
- LOCK_DRAIN lasts 0–1 cycles. It lasts 1 cycle only if a grant was issued in the cycle `l_lock_i` rose.
- A reset asserted between gnt and rvalid suppresses that rvalid. No stale response may appear after reset.
- Lock deassert with a loader request pending: that request is still granted in the same cycle, and round-robin resumes next cycle.

## Configuration
- `IMEM_ARB_FIXED_PRIO_EN`:
  - Defined: fetch always wins contention in ARB, and the last-grant pointer is not implemented.
  - Undefined: round-robin as specified above.
- Lock behaviour is identical in both builds.

## Structure
- Package `imem_arb_pkg` holds:
  - `arb_state_t` enum (ARB, LOCK_DRAIN, LOCKED);
  - `port_t` enum (PORT_FETCH, PORT_LOADER);
  - `MEM_BYTES_DEF`, `DEPTH_WORDS_DEF`, `ERR_RDATA`=32'h0.
- Sub-module `rr_arb2` is a two-requester round-robin grant with a pointer register and an `en_i` mask input. The fixed-priority build bypasses its pointer.

## Test plan
- After reset, `f_req_i`=1 with `f_addr_i`=0x10 → `f_gnt_o`=1 in the same cycle, `mem_addr_o`=4, `f_rvalid_o`=1 next cycle with `f_rdata_o`=`mem_rdata_i`.
- Both ports request reads every cycle for 6 cycles → grants alternate F,L,F,L,F,L. Each rvalid goes only to its owner, with zero-filled rdata on the other port.
- Loader write to 0x20 with wdata 0xDEADBEEF → `mem_we_o`=1, `mem_addr_o`=8. `l_rvalid_o`=1 next cycle with rdata 0. A following fetch read of 0x20 returns the memory value.
- Fetch read of 0x1000 and loader read of 0x6 → both granted with no `mem_en_o`; responses carry rdata 0, err 1.
- `l_lock_i` rises in the same cycle as a fetch grant → LOCK_DRAIN for 1 cycle, then `l_locked_o`=1. `f_gnt_o` stays 0 for 10 cycles while loader writes proceed. `l_lock_i`=0 → fetch granted next cycle.
- `rst_i`=0 for 1 cycle immediately after a fetch grant → no `f_rvalid_o`; all outputs read 0 and the FSM is in ARB.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        ARB        = 2'd0,
        LOCK_DRAIN = 2'd1,
        LOCKED     = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_FETCH  = 1'b0,
        PORT_LOADER = 1'b1
    } port_t;

    localparam int unsigned MEM_BYTES_DEF   = 4096;
    localparam int unsigned DEPTH_WORDS_DEF = 1024;
    localparam logic [31:0] ERR_RDATA       = 32'h0;

    // An access reaches the memory only if it is in range and word aligned.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr < mem_bytes) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester grant (bit 0 = fetch, bit 1 = loader) with per-requester enable mask.
// IMEM_ARB_FIXED_PRIO_EN: fetch always wins and no last-grant pointer exists.
module rr_arb2
    import imem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] en_i,
    output logic [1:0] gnt_o
);

    logic [1:0] req_m;
    assign req_m = req_i & en_i;

`ifdef IMEM_ARB_FIXED_PRIO_EN
    assign gnt_o = {req_m[1] & ~req_m[0], req_m[0]};
`else
    port_t last_reg, last_next;

    always_comb begin
        gnt_o     = req_m;
        last_next = last_reg;
        if (req_m == 2'b11) begin
            gnt_o = (last_reg == PORT_LOADER) ? 2'b01 : 2'b10;
        end
        if (gnt_o[0]) begin
            last_next = PORT_FETCH;
        end else if (gnt_o[1]) begin
            last_next = PORT_LOADER;
        end
    end

    // Pointer starts at the loader so fetch wins the first contention.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_reg <= PORT_LOADER;
        end else begin
            last_reg <= last_next;
        end
    end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction memory between fetch and loader, with a loader lock FSM.
// Arbitration policy depends on IMEM_ARB_FIXED_PRIO_EN (see rr_arb2).
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF,
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           f_req_i,
    input  logic [31:0]                    f_addr_i,
    output logic                           f_gnt_o,
    output logic                           f_rvalid_o,
    output logic [31:0]                    f_rdata_o,
    output logic                           f_err_o,
    input  logic                           l_req_i,
    input  logic                           l_we_i,
    input  logic [31:0]                    l_addr_i,
    input  logic [31:0]                    l_wdata_i,
    input  logic                           l_lock_i,
    output logic                           l_gnt_o,
    output logic                           l_rvalid_o,
    output logic [31:0]                    l_rdata_o,
    output logic                           l_err_o,
    output logic                           l_locked_o,
    output logic                           mem_en_o,
    output logic                           mem_we_o,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                    mem_wdata_o,
    input  logic [31:0]                    mem_rdata_i
);

    localparam int AW = $clog2(DEPTH_WORDS);

    arb_state_t  state_reg, state_next;
    logic        rsp_valid_reg;
    port_t       rsp_owner_reg;
    logic        rsp_err_reg;
    logic        rsp_we_reg;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        any_gnt;
    logic [31:0] addr;
    logic        ok;
    logic        rsp_live;
    logic [31:0] rsp_rdata;

    // Requests are masked while reset is held so nothing is granted in a reset cycle.
    assign req = {l_req_i, f_req_i} & {2{rst_i}};

    rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req),
        .en_i  ({1'b1, state_reg == ARB}),
        .gnt_o (gnt)
    );

    assign f_gnt_o = gnt[0];
    assign l_gnt_o = gnt[1];
    assign any_gnt = |gnt;
    assign addr    = gnt[1] ? l_addr_i : f_addr_i;
    assign ok      = addr_ok(addr, MEM_BYTES);

    assign mem_en_o    = any_gnt && ok;
    assign mem_we_o    = gnt[1] && ok && l_we_i;
    assign mem_addr_o  = mem_en_o ? addr[AW+1:2] : '0;
    assign mem_wdata_o = mem_we_o ? l_wdata_i : '0;

    // Drain is needed only when a response is in flight at the moment lock is requested.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB:        if (l_lock_i) state_next = any_gnt ? LOCK_DRAIN : LOCKED;
            LOCK_DRAIN: state_next = l_lock_i ? LOCKED : ARB;
            LOCKED:     if (!l_lock_i) state_next = ARB;
            default:    state_next = ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg     <= ARB;
            rsp_valid_reg <= 1'b0;
            rsp_owner_reg <= PORT_FETCH;
            rsp_err_reg   <= 1'b0;
            rsp_we_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= any_gnt;
            rsp_owner_reg <= gnt[1] ? PORT_LOADER : PORT_FETCH;
            rsp_err_reg   <= any_gnt && !ok;
            rsp_we_reg    <= gnt[1] && l_we_i;
        end
    end

    // Gating with rst_i keeps an in-flight response from surfacing during a reset cycle.
    assign rsp_live  = rsp_valid_reg && rst_i;
    assign rsp_rdata = rsp_err_reg ? ERR_RDATA : (rsp_we_reg ? 32'h0 : mem_rdata_i);

    assign f_rvalid_o = rsp_live && (rsp_owner_reg == PORT_FETCH);
    assign f_rdata_o  = f_rvalid_o ? rsp_rdata : 32'h0;
    assign f_err_o    = f_rvalid_o && rsp_err_reg;
    assign l_rvalid_o = rsp_live && (rsp_owner_reg == PORT_LOADER);
    assign l_rdata_o  = l_rvalid_o ? rsp_rdata : 32'h0;
    assign l_err_o    = l_rvalid_o && rsp_err_reg;
    assign l_locked_o = (state_reg == LOCKED) && rst_i;

endmodule
